// File: rtl/phase_rx_pkg.sv
// rtl/phase_rx_pkg.sv - dual-rail code constants, FSM state type and one-hot helper for phase_sync_rx
package phase_rx_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    HOLD      = 1'b1
  } rx_state_t;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/phase_rx_sync.sv
// rtl/phase_rx_sync.sv - single-bit STAGES-deep async-reset synchronizer for one dual-rail wire
module phase_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/phase_sync_rx.sv
// rtl/phase_sync_rx.sv - clocked completion detector for the PH0/PH1/PH2 dual-rail ring; watchdog under PHASE_RX_TIMEOUT_EN
module phase_sync_rx
  import phase_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ph0,
  input  logic [1:0] ph1,
  input  logic [1:0] ph2,
  output logic       ack,
  output logic [2:0] phase_oh,
  output logic       phase_vld,
  output logic       phase_err,
  output logic       timeout
);

  logic [5:0] raw;
  logic [5:0] rail;

  assign raw = {ph2, ph1, ph0};

  // Every rail is synchronized on its own; only the synchronized copies are decoded.
  for (genvar i = 0; i < 6; i++) begin : g_rail
    phase_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (raw[i]),
      .q     (rail[i])
    );
  end

  logic [1:0] c0, c1, c2;
  logic       all_valid, all_null, any_ill;
  logic [2:0] dat1;

  assign c0 = rail[1:0];
  assign c1 = rail[3:2];
  assign c2 = rail[5:4];

  assign all_valid = (c0 != DR_NULL) && (c1 != DR_NULL) && (c2 != DR_NULL);
  assign all_null  = (c0 == DR_NULL) && (c1 == DR_NULL) && (c2 == DR_NULL);
  assign any_ill   = (c0 == DR_ILL) || (c1 == DR_ILL) || (c2 == DR_ILL);
  assign dat1      = {c2 == DR_ONE, c1 == DR_ONE, c0 == DR_ONE};

  rx_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_DATA;
      ack       <= 1'b0;
      phase_oh  <= 3'b000;
      phase_vld <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      phase_vld <= 1'b0;
      phase_err <= 1'b0;
      case (state)
        WAIT_DATA: begin
          if (all_valid) begin
            state     <= HOLD;
            ack       <= 1'b1;
            phase_oh  <= dat1;
            phase_vld <= 1'b1;
            // ack still rises on a bad wave so the ring can never deadlock
            phase_err <= any_ill || !is_one_hot3(dat1);
          end
        end
        HOLD: begin
          if (all_null) begin
            state <= WAIT_DATA;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_DATA;
          ack   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHASE_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic          state_chg;

  assign state_chg = (state == WAIT_DATA) ? all_valid : all_null;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state_chg) begin
        stall_cnt <= '0;
      end else if (stall_cnt != CW'(TIMEOUT_CYCLES)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (stall_cnt == CW'(TIMEOUT_CYCLES)) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sync_rx.sv
// tb/tb_phase_sync_rx.sv - directed self-checking bench for phase_sync_rx (SYNC_STAGES=2, TIMEOUT_CYCLES=16)
module tb_phase_sync_rx;

  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] ph0, ph1, ph2;
  logic       ack;
  logic [2:0] phase_oh;
  logic       phase_vld;
  logic       phase_err;
  logic       timeout;

  int n_pass  = 0;
  int n_total = 0;

  phase_sync_rx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ph0       (ph0),
    .ph1       (ph1),
    .ph2       (ph2),
    .ack       (ack),
    .phase_oh  (phase_oh),
    .phase_vld (phase_vld),
    .phase_err (phase_err),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ph(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    ph0 = a;
    ph1 = b;
    ph2 = c;
  endtask

  // Full handshake: data wave in, check capture timing, then ring returns to NULL.
  task automatic wave(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [2:0] exp_oh, input logic exp_err);
    set_ph(a, b, c);
    for (int i = 0; i < S; i++) step();
    check({tag, "_ack_early"}, ack, 0);
    check({tag, "_vld_early"}, phase_vld, 0);
    step();
    check({tag, "_ack_rise"}, ack, 1);
    check({tag, "_vld"}, phase_vld, 1);
    check({tag, "_oh"}, phase_oh, exp_oh);
    check({tag, "_err"}, phase_err, exp_err);
    step();
    check({tag, "_vld_once"}, phase_vld, 0);
    check({tag, "_err_once"}, phase_err, 0);
    set_ph(2'b00, 2'b00, 2'b00);
    for (int i = 0; i < S; i++) step();
    check({tag, "_ack_hold"}, ack, 1);
    step();
    check({tag, "_ack_fall"}, ack, 0);
    check({tag, "_oh_held"}, phase_oh, exp_oh);
  endtask

  initial begin
    logic seen_vld;
    logic exp_to;

    // reset with garbage on the rails
    rst_n = 1'b0;
    set_ph(2'b10, 2'b11, 2'b01);
    step(); step(); step();
    check("rst_ack", ack, 0);
    check("rst_oh", phase_oh, 3'b000);
    check("rst_vld", phase_vld, 0);
    check("rst_err", phase_err, 0);
    check("rst_timeout", timeout, 0);
    set_ph(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("post_rst_ack", ack, 0);

    // rotation
    wave("rot0", 2'b10, 2'b01, 2'b01, 3'b001, 1'b0);
    wave("rot1", 2'b01, 2'b10, 2'b01, 3'b010, 1'b0);
    wave("rot2", 2'b01, 2'b01, 2'b10, 3'b100, 1'b0);

    // skewed arrival, including a channel dropping back to NULL early
    seen_vld = 1'b0;
    ph0 = 2'b10;
    for (int i = 0; i < 5; i++) begin step(); seen_vld |= phase_vld | ack; end
    ph1 = 2'b01;
    for (int i = 0; i < 3; i++) begin step(); seen_vld |= phase_vld | ack; end
    ph1 = 2'b00;
    for (int i = 0; i < 2; i++) begin step(); seen_vld |= phase_vld | ack; end
    ph1 = 2'b01;
    for (int i = 0; i < 5; i++) begin step(); seen_vld |= phase_vld | ack; end
    check("skew_no_early_strobe", seen_vld, 0);
    wave("skew", 2'b10, 2'b01, 2'b01, 3'b001, 1'b0);

    // illegal waves
    wave("ill11", 2'b10, 2'b11, 2'b01, 3'b001, 1'b1);
    wave("twohot", 2'b10, 2'b10, 2'b01, 3'b011, 1'b1);
    wave("zerohot", 2'b01, 2'b01, 2'b01, 3'b000, 1'b1);

    // reset mid-HOLD
    set_ph(2'b01, 2'b01, 2'b10);
    for (int i = 0; i < S + 1; i++) step();
    check("midhold_ack_up", ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midhold_ack_async", ack, 0);
    check("midhold_oh_async", phase_oh, 3'b000);
    set_ph(2'b00, 2'b00, 2'b00);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("midhold_release_ack", ack, 0);
    wave("after_rst", 2'b01, 2'b10, 2'b01, 3'b010, 1'b0);

    // stall with one channel stuck NULL
`ifdef PHASE_RX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    set_ph(2'b00, 2'b01, 2'b10);
    for (int i = 0; i < 30; i++) step();
    check("stall_ack", ack, 0);
    check("stall_timeout", timeout, exp_to);
    for (int i = 0; i < 5; i++) step();
    check("stall_timeout_sticky", timeout, exp_to);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/phase_sync_rx.md
# phase_sync_rx

Clocked receiving end of the dual-rail phase channels PH0/PH1/PH2 produced by the asynchronous phase ring. The block synchronizes the six rails into the `clk` domain and performs completion detection across all three channels. It acknowledges each data wave and each null wave on the shared 4-phase `ack`, and presents the decoded active phase to synchronous logic as a one-hot vector with a valid strobe. It sits at the async/sync boundary; its `ack` drives the ring's shared `ack` input.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each rail synchronizer; legal range 2..4.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in `clk` cycles. Used only with `PHASE_RX_TIMEOUT_EN`.

- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `ph0` input 2: dual-rail channel 0. `[1]` is the true rail, `[0]` is the false rail.
- `ph1` input 2: dual-rail channel 1, same encoding.
- `ph2` input 2: dual-rail channel 2, same encoding.
- `ack` output 1: 4-phase acknowledge to the ring.
- `phase_oh` output 3: last accepted phase, one-hot, with bit n = PHn. Held between waves.
- `phase_vld` output 1: one-cycle pulse when `phase_oh` updates.
- `phase_err` output 1: one-cycle pulse when a wave is illegal.
- `timeout` output 1: sticky stall flag. Tied to 0 when the watchdog is compiled out.

## Operation
- Rail codes per channel:
  - 00 = NULL (spacer)
  - 01 = DATA0
  - 10 = DATA1
  - 11 = ILLEGAL
- Each of the six rails passes through its own `SYNC_STAGES`-flop synchronizer. No other logic reads the raw inputs.
- Per channel, on synchronized codes:
  - `valid_n` = code is not 00.
  - `null_n` = code is 00.
- FSM, two states:
  - **WAIT_DATA** (reset state, `ack`=0): stay while any channel is NULL. When all three channels are valid:
    - go to HOLD and set `ack`=1;
    - capture `phase_oh[n]` = (channel n == DATA1);
    - pulse `phase_vld`.
  - **HOLD** (`ack`=1): stay while any channel is non-NULL. When all three channels are NULL, go to WAIT_DATA and set `ack`=0.
- A wave is illegal if any channel is 11, or if the captured vector is not exactly one-hot (zero or two or more DATA1).
  - On an illegal wave, `phase_err` pulses together with `phase_vld`.
  - `phase_oh` still captures the raw vector.
  - `ack` still rises. The ring must never deadlock on an error.
- A partial wave (some channels valid, some NULL) causes no output change. The FSM keeps waiting; completion detection is monotonic.
- A channel returning to NULL early while in WAIT_DATA has no effect other than continued waiting.
- Reset mid-handshake: all synchronizers, the FSM and the outputs clear immediately. The ring is gated by the same `rst_n`, so after release both sides start from NULL with `ack`=0.
- Reset values:
  - `ack`=0, `phase_oh`=3'b000, `phase_vld`=0, `phase_err`=0, `timeout`=0;
  - FSM in WAIT_DATA.

## Timing
- All outputs are registered on the rising edge of `clk`.
- Let edge 1 be the first rising edge after the last channel becomes valid with setup met.
  - `ack` rises on edge `SYNC_STAGES`+1.
  - `phase_vld` and `phase_oh` update on the same edge.
- `ack` falls `SYNC_STAGES`+1 edges after the last channel returns to NULL.
- Minimum full handshake is 2×(`SYNC_STAGES`+1) cycles plus ring delay.
- `phase_vld` is high for exactly one cycle per data wave. It never pulses twice without an intervening null wave.

## Configuration
- `PHASE_RX_TIMEOUT_EN` defined:
  - a counter of width clog2(`TIMEOUT_CYCLES`+1) increments every cycle the FSM stays in one state;
  - it clears on every state transition;
  - on reaching `TIMEOUT_CYCLES`, `timeout` sets and stays set until reset;
  - the counter saturates and does not wrap.
- Not defined: no counter is built and `timeout` is the constant 0.

## Structure
- Package `phase_rx_pkg` holds:
  - the rail code constants `DR_NULL`, `DR_ZERO`, `DR_ONE`, `DR_ILL`;
  - the FSM state type `{WAIT_DATA, HOLD}`.
- Sub-module `phase_rx_sync`: one parameterized `STAGES`-deep, single-bit, async-reset synchronizer, instantiated six times.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary ph inputs. Expect `ack`=0, `phase_oh`=000, no pulses. After release with all NULL, `ack` stays 0.
- Rotation: drive waves ph0/ph1/ph2 = 10/01/01, then NULL, then 01/10/01, then NULL, then 01/01/10, with the ring responding to `ack`. Expect `phase_oh` = 001, 010, 100, one `phase_vld` each, `ack` edges at `SYNC_STAGES`+1 latency, and `phase_err`=0.
- Skewed arrival: raise ph0, ph1, ph2 five cycles apart. Expect `ack` rises `SYNC_STAGES`+1 edges after ph2 only, with no earlier strobes.
- Illegal code: ph1=11 with the others valid. Expect `phase_err` and `phase_vld` pulse together and `ack` rises. Two-hot 10/10/01 gives the same response with `phase_oh`=011.
- Reset mid-HOLD: assert `rst_n`=0 while `ack`=1. Expect `ack`=0 asynchronously and the FSM back in WAIT_DATA on release.
- `PHASE_RX_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16: hold one channel NULL indefinitely. Expect `timeout`=1 after 16 cycles, staying high until reset. With the macro undefined, `timeout` stays 0.
